// File: rtl/hsi_mse_acc.sv
// Per-reference squared-error accumulator: one band pair per cycle in, one saturated MSE per vector out.
// HSI_MSE_ACC_ROUND_EN selects round-half-up for the mean; when it is undefined, the mean is truncated.
module hsi_mse_acc #(
  parameter int unsigned DATA_WIDTH            = 16,
  parameter int unsigned HSI_BANDS             = 128,
  parameter int unsigned HSI_LIBRARY_SIZE      = 256,
  parameter int unsigned HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE),
  parameter int unsigned HSI_BANDS_ADDR        = $clog2(HSI_BANDS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             band_valid,
  output logic                             band_ready,
  input  logic [DATA_WIDTH-1:0]            sample_band,
  input  logic [DATA_WIDTH-1:0]            ref_band,
  input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] ref_id_in,
  input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] library_length_in,
  output logic                             mse_valid,
  input  logic                             mse_ready,
  output logic [DATA_WIDTH-1:0]            mse_out,
  output logic [HSI_LIBRARY_SIZE_ADDR-1:0] ref_id_out,
  input  logic                             start,
  output logic                             done,
  output logic                             idle,
  output logic                             ready
);

  localparam int unsigned SQ_W  = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W = SQ_W + HSI_BANDS_ADDR;
  localparam int unsigned LEN_W = HSI_LIBRARY_SIZE_ADDR + 1;
`ifdef HSI_MSE_ACC_ROUND_EN
  localparam int unsigned SUM_W = ACC_W + 1;
`else
  localparam int unsigned SUM_W = ACC_W;
`endif

  typedef enum logic [2:0] {StIdle, StAccum, StDrain, StOut, StDone} state_e;

  state_e                            r_state, w_state_next;
  logic [HSI_BANDS_ADDR-1:0]         r_band_cnt;
  logic [1:0]                        r_drain_cnt;
  logic [LEN_W-1:0]                  r_len;
  logic [LEN_W-1:0]                  r_vec_cnt;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0]  r_ref_id;
  logic                              r_diff_vld;
  logic signed [DATA_WIDTH:0]        r_diff;
  logic                              r_sq_vld;
  logic [SQ_W-1:0]                   r_sq;
  logic [ACC_W-1:0]                  r_acc;
  logic                              r_mse_valid;
  logic [DATA_WIDTH-1:0]             r_mse;
  logic [HSI_LIBRARY_SIZE_ADDR-1:0]  r_ref_id_out;

  logic                              w_accept;
  logic                              w_first_band;
  logic                              w_last_band;
  logic                              w_out_fire;
  logic                              w_last_vec;
  logic [SUM_W-1:0]                  w_sum;
  logic [SUM_W-1:0]                  w_mean;
  logic [DATA_WIDTH-1:0]             w_sat;

  assign w_accept     = band_valid && (r_state == StAccum);
  assign w_first_band = (r_band_cnt == '0);
  assign w_last_band  = (r_band_cnt == HSI_BANDS_ADDR'(HSI_BANDS - 1));
  assign w_out_fire   = (r_state == StOut) && r_mse_valid && mse_ready;
  assign w_last_vec   = ((r_vec_cnt + LEN_W'(1)) == r_len);

  always_comb begin
`ifdef HSI_MSE_ACC_ROUND_EN
    // One extra bit keeps the rounding constant from wrapping a full accumulator.
    w_sum = {1'b0, r_acc} + SUM_W'(HSI_BANDS / 2);
`else
    w_sum = r_acc;
`endif
    w_mean = w_sum >> HSI_BANDS_ADDR;
    w_sat  = (|w_mean[SUM_W-1:DATA_WIDTH]) ? '1 : w_mean[DATA_WIDTH-1:0];
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StAccum;
      StAccum: if (w_accept && w_last_band) w_state_next = StDrain;
      StDrain: if (r_drain_cnt == 2'd2) w_state_next = StOut;
      StOut:   if (w_out_fire) w_state_next = w_last_vec ? StDone : StAccum;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign band_ready = (r_state == StAccum);
  assign idle       = (r_state == StIdle);
  assign ready      = (r_state == StIdle);
  assign done       = (r_state == StDone);
  assign mse_valid  = r_mse_valid;
  assign mse_out    = r_mse;
  assign ref_id_out = r_ref_id_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_vec_cnt   <= '0;
      r_band_cnt  <= '0;
      r_drain_cnt <= '0;
      r_ref_id    <= '0;
    end else begin
      if ((r_state == StIdle) && start) begin
        r_len      <= (library_length_in == '0) ? LEN_W'(HSI_LIBRARY_SIZE)
                                                : LEN_W'(library_length_in);
        r_vec_cnt  <= '0;
        r_band_cnt <= '0;
      end
      if (w_accept) begin
        r_band_cnt <= r_band_cnt + HSI_BANDS_ADDR'(1);
        if (w_first_band) r_ref_id <= ref_id_in;
      end
      r_drain_cnt <= (r_state == StDrain) ? r_drain_cnt + 2'd1 : 2'd0;
      if (w_out_fire) r_vec_cnt <= r_vec_cnt + LEN_W'(1);
    end
  end

  // Three-stage datapath: difference, square, accumulate. Valid bits gate every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff_vld <= 1'b0;
      r_diff     <= '0;
      r_sq_vld   <= 1'b0;
      r_sq       <= '0;
      r_acc      <= '0;
    end else begin
      r_diff_vld <= w_accept;
      if (w_accept) begin
        r_diff <= $signed({1'b0, sample_band}) - $signed({1'b0, ref_band});
      end
      r_sq_vld <= r_diff_vld;
      if (r_diff_vld) r_sq <= SQ_W'(r_diff * r_diff);
      if (w_accept && w_first_band) begin
        r_acc <= '0;
      end else if (r_sq_vld) begin
        r_acc <= r_acc + ACC_W'(r_sq);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mse_valid  <= 1'b0;
      r_mse        <= '0;
      r_ref_id_out <= '0;
    end else begin
      if ((r_state == StOut) && !r_mse_valid) begin
        r_mse_valid  <= 1'b1;
        r_mse        <= w_sat;
        r_ref_id_out <= r_ref_id;
      end else if (w_out_fire) begin
        r_mse_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hsi_mse_acc.sv
// Directed bench for hsi_mse_acc (HSI_BANDS=4): scoreboard model of the per-vector mean squared error.
module tb_hsi_mse_acc;

  localparam int DW    = 16;
  localparam int BANDS = 4;
  localparam int LIB   = 16;
  localparam int IDW   = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           band_valid;
  logic           band_ready;
  logic [DW-1:0]  sample_band;
  logic [DW-1:0]  ref_band;
  logic [IDW-1:0] ref_id_in;
  logic [IDW-1:0] library_length_in;
  logic           mse_valid;
  logic           mse_ready;
  logic [DW-1:0]  mse_out;
  logic [IDW-1:0] ref_id_out;
  logic           start;
  logic           done;
  logic           idle;
  logic           ready;

  hsi_mse_acc #(
    .DATA_WIDTH      (DW),
    .HSI_BANDS       (BANDS),
    .HSI_LIBRARY_SIZE(LIB)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .band_valid       (band_valid),
    .band_ready       (band_ready),
    .sample_band      (sample_band),
    .ref_band         (ref_band),
    .ref_id_in        (ref_id_in),
    .library_length_in(library_length_in),
    .mse_valid        (mse_valid),
    .mse_ready        (mse_ready),
    .mse_out          (mse_out),
    .ref_id_out       (ref_id_out),
    .start            (start),
    .done             (done),
    .idle             (idle),
    .ready            (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  mse;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last_acc_cyc = 0;
  int            n_results = 0;
  int            done_cnt = 0;
  int            done_base = 0;
  logic [DW-1:0] last_mse = '0;
  logic [IDW-1:0] last_id = '0;
  logic [DW-1:0] s_arr [BANDS];
  logic [DW-1:0] r_arr [BANDS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mean of squared differences from plain integer arithmetic.
  function automatic logic [DW-1:0] model_mse();
    longint sum = 0;
    longint mean;
    for (int b = 0; b < BANDS; b++) begin
      longint d = longint'(s_arr[b]) - longint'(r_arr[b]);
      sum += d * d;
    end
`ifdef HSI_MSE_ACC_ROUND_EN
    mean = (sum + BANDS / 2) / BANDS;
`else
    mean = sum / BANDS;
`endif
    if (mean > 65535) mean = 65535;
    return DW'(mean);
  endfunction

  // Compare process: every cycle a result is presented it must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (mse_valid) begin
        chk("band_ready_low_while_out", band_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("mse_out", mse_out, exp_q[0].mse);
          chk("ref_id_out", ref_id_out, exp_q[0].id);
          if (mse_ready) begin
            last_mse = mse_out;
            last_id  = ref_id_out;
            n_results++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_band_ready"}, band_ready, 0);
    chk({tag, "_mse_valid"}, mse_valid, 0);
    chk({tag, "_mse_out"}, mse_out, 0);
    chk({tag, "_ref_id_out"}, ref_id_out, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_idle"}, idle, 1);
    chk({tag, "_ready"}, ready, 1);
  endtask

  task automatic do_start(input logic [IDW-1:0] len);
    done_base = done_cnt;
    start = 1'b1;
    library_length_in = len;
    @(negedge clk);
    start = 1'b0;
    chk("band_ready_after_start", band_ready, 1);
    chk("idle_after_start", idle, 0);
  endtask

  task automatic send_band(input logic [DW-1:0] s, input logic [DW-1:0] r,
                           input logic [IDW-1:0] id);
    int n = 0;
    band_valid  = 1'b1;
    sample_band = s;
    ref_band    = r;
    ref_id_in   = id;
    while (!band_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("band_accept_timeout", 1, 0);
      band_valid = 1'b0;
    end else begin
      @(negedge clk);
      band_valid   = 1'b0;
      last_acc_cyc = cyc;
    end
  endtask

  task automatic send_vector(input logic [IDW-1:0] id, input int max_gap);
    exp_t e;
    for (int b = 0; b < BANDS; b++) begin
      int g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) @(negedge clk);
      send_band(s_arr[b], r_arr[b], id);
    end
    e.mse = model_mse();
    e.id  = id;
    exp_q.push_back(e);
  endtask

  task automatic fill(input int s0, input int s1, input int s2, input int s3,
                      input int r0, input int r1, input int r2, input int r3);
    s_arr[0] = DW'(s0); s_arr[1] = DW'(s1); s_arr[2] = DW'(s2); s_arr[3] = DW'(s3);
    r_arr[0] = DW'(r0); r_arr[1] = DW'(r1); r_arr[2] = DW'(r2); r_arr[3] = DW'(r3);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, (n < 2000), 1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_idle_back"}, idle, 1);
    chk({tag, "_ready_back"}, ready, 1);
    chk({tag, "_done_pulses"}, done_cnt - done_base, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n0;
    rst_n = 1'b0;
    band_valid = 1'b0;
    sample_band = '0;
    ref_band = '0;
    ref_id_in = '0;
    library_length_in = '0;
    mse_ready = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: (10-6)^2 * 4 = 64, mean 16, plus result latency
    do_start(4'd1);
    fill(10, 10, 10, 10, 6, 6, 6, 6);
    send_vector(4'd5, 0);
    n = 0;
    while (!mse_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency_cycles", cyc - last_acc_cyc, 4);
    wait_done("basic");
    chk("basic_mse_literal", last_mse, 16);
    chk("basic_id_literal", last_id, 5);

    // Rounding: sum 2 -> 0 truncated, 1 rounded
    do_start(4'd1);
    fill(0, 0, 0, 0, 1, 1, 0, 0);
    send_vector(4'd1, 0);
    wait_done("round");
`ifdef HSI_MSE_ACC_ROUND_EN
    chk("round_mse_literal", last_mse, 1);
`else
    chk("round_mse_literal", last_mse, 0);
`endif

    // Saturation in both difference directions
    do_start(4'd2);
    fill(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
    send_vector(4'd2, 0);
    chk("sat_pos_mse_literal", model_mse(), 16'hFFFF);
    fill(0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    send_vector(4'd3, 0);
    wait_done("sat");
    chk("sat_neg_mse_literal", last_mse, 16'hFFFF);

    // Multi-vector with a 10-cycle output stall on vector 8
    do_start(4'd3);
    fill(1, 2, 3, 4, 5, 5, 5, 5);
    send_vector(4'd7, 0);
    fill(50, 60, 70, 80, 40, 70, 70, 100);
    send_vector(4'd8, 0);
    mse_ready = 1'b0;
    n = 0;
    while (!mse_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_result_seen", mse_valid, 1);
    repeat (10) begin
      @(negedge clk);
      chk("stall_band_ready", band_ready, 0);
      chk("stall_mse_valid", mse_valid, 1);
    end
    @(posedge clk);
    #1 mse_ready = 1'b1;
    @(negedge clk);
    fill(9, 9, 9, 9, 0, 0, 0, 0);
    send_vector(4'd9, 0);
    wait_done("multi");
    chk("multi_last_id_literal", last_id, 9);
    chk("multi_last_mse_literal", last_mse, 81);

    // Bubbles: d = -10,10,-30,50 -> 3600/4 = 900
    do_start(4'd1);
    fill(100, 200, 300, 400, 110, 190, 330, 350);
    send_vector(4'd4, 3);
    wait_done("bubble");
    chk("bubble_mse_literal", last_mse, 900);

    // Reset after two bands, then a fresh run
    do_start(4'd1);
    send_band(16'd500, 16'd0, 4'd6);
    send_band(16'd500, 16'd0, 4'd6);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(4'd1);
    fill(300, 0, 5, 7, 0, 300, 9, 7);
    send_vector(4'd10, 0);
    wait_done("fresh");
    chk("fresh_mse_literal", last_mse, 45004);
    chk("fresh_id_literal", last_id, 10);

    // Length 0 means the full library
    n0 = n_results;
    do_start(4'd0);
    for (int i = 0; i < LIB; i++) begin
      fill(i * 3, i * 3 + 1, i * 3 + 2, i * 3 + 3, i, i + 2, i + 4, i + 6);
      send_vector(IDW'(i), 0);
    end
    wait_done("len0");
    chk("len0_result_count", n_results - n0, LIB);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
